// File: rtl/gray_frame_collector.sv
// Captures one FRAME_LEN-word gray frame after each rising edge of done, keeps a
// modulo-2^DATA_W checksum of it, and serves the frame through a registered read port.
module gray_frame_collector #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [DATA_W-1:0] Gray,
    input  logic              ack,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    output logic              busy,
    output logic [DATA_W-1:0] frame_sum,
    output logic              err_overrun
);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_EXT   = (ADDR_W + 1)'(FRAME_LEN);

    state_t            state;
    state_t            state_nxt;
    logic              done_d;
    logic              rise;
    logic              last_word;
    logic              capture_en;
    logic              clear_en;
    logic              rd_ok;
    logic [ADDR_W-1:0] wcnt;
    logic [DATA_W-1:0] frame_mem [FRAME_LEN];

    assign rise      = done & ~done_d;
    assign last_word = (wcnt == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_d <= done;
        end
    end

    always_comb begin
        state_nxt   = state;
        capture_en  = 1'b0;
        clear_en    = 1'b0;
        rd_ok       = 1'b0;
        busy        = 1'b0;
        frame_ready = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = CAPTURE;
                    clear_en  = 1'b1;
                end
            end
            CAPTURE: begin
                busy       = 1'b1;
                capture_en = 1'b1;
                if (last_word) state_nxt = READY;
            end
            READY: begin
                frame_ready = 1'b1;
                rd_ok       = rd_en && ({1'b0, rd_addr} < LEN_EXT);
                // A rise coinciding with ack is left unconsumed; the host must re-arm.
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The previous frame's sum survives in IDLE and is only cleared when a new capture starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt        <= '0;
            frame_sum   <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (clear_en) begin
                wcnt      <= '0;
                frame_sum <= '0;
            end else if (capture_en) begin
                wcnt      <= wcnt + 1'b1;
                frame_sum <= frame_sum + Gray;
            end
            if (rise && (state != IDLE)) err_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_en) frame_mem[wcnt] <= Gray;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= frame_mem[rd_addr];
        end
    end

endmodule
